// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the DRAM port arbiter: host FSM states,
// default bus widths and the grant encoding used to steer the DRAM mux.
package mem_arb_pkg;

   typedef enum logic {
      HOST_IDLE = 1'b0,
      HOST_ACK  = 1'b1
   } host_state_t;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   localparam logic [1:0] GNT_NONE = 2'd0;
   localparam logic [1:0] GNT_CPU  = 2'd1;
   localparam logic [1:0] GNT_HOST = 2'd2;

   function automatic logic [1:0] grant_code(input logic gnt_host, input logic gnt_cpu);
      logic [1:0] code;
      code = GNT_NONE;
      if (gnt_host)
         code = GNT_HOST;
      else if (gnt_cpu)
         code = GNT_CPU;
      return code;
   endfunction

endpackage

// File: rtl/dram_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
   parameter int WIDTH = 8,
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic at_limit
);

   localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

   logic [WIDTH-1:0] cnt_reg;

   assign at_limit = (cnt_reg >= LIMIT_W);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt_reg <= '0;
      else if (clr)
         cnt_reg <= '0;
      else if (inc && !at_limit)
         cnt_reg <= cnt_reg + 1'b1;
   end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares one DRAM data port between the CPU (priority) and a host loader that
// is guaranteed a slot after STARVE_LIMIT lost cycles; host completes with a one-cycle ack.
module dram_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_ack,
   output logic              dram_we,
   output logic [ADDR_W-1:0] dram_addr,
   output logic [DATA_W-1:0] dram_wdata,
   input  logic [DATA_W-1:0] dram_rdata
);

   host_state_t       state_reg, state_next;
   logic [DATA_W-1:0] host_rdata_reg;
   logic              host_eligible;
   logic              grant_host;
   logic              grant_cpu;
   logic [1:0]        grant_sel;
   logic              starved;
   logic              cnt_clr;
   logic              cnt_inc;

   assign host_eligible = host_req && (state_reg == HOST_IDLE);
   assign grant_host    = host_eligible && (!cpu_req || starved);
   assign grant_cpu     = cpu_req && !grant_host;
   assign grant_sel     = grant_code(grant_host, grant_cpu);

   // Waiting only counts while the host is actually competing; dropping the
   // request or winning a slot restarts the starvation window.
   assign cnt_clr = !host_req || grant_host;
   assign cnt_inc = host_eligible && grant_cpu;

   sat_counter #(
      .WIDTH (CNT_W),
      .LIMIT (STARVE_LIMIT)
   ) u_starve_cnt (
      .clk      (clk),
      .reset    (reset),
      .clr      (cnt_clr),
      .inc      (cnt_inc),
      .at_limit (starved)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         HOST_IDLE: if (grant_host) state_next = HOST_ACK;
         HOST_ACK:  state_next = HOST_IDLE;
         default:   state_next = HOST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= HOST_IDLE;
         host_rdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (grant_host)
            host_rdata_reg <= dram_rdata;
      end
   end

   always_comb begin
      dram_we    = 1'b0;
      dram_addr  = cpu_addr;
      dram_wdata = cpu_wdata;
      case (grant_sel)
         GNT_HOST: begin
            dram_we    = host_we;
            dram_addr  = host_addr;
            dram_wdata = host_wdata;
         end
         GNT_CPU:  dram_we = cpu_we;
         default:  dram_we = 1'b0;
      endcase
   end

   assign cpu_rdata  = dram_rdata;
   assign cpu_stall  = cpu_req && grant_host;
   assign host_ack   = (state_reg == HOST_ACK);
   assign host_rdata = host_rdata_reg;

endmodule
